// File: rtl/dmem_if.sv
// dmem_if: request/response bus between the load/store unit and dmem_ctrl.
//   master : load/store unit (drives requests, accepts responses)
//   slave  : dmem_ctrl       (accepts requests, drives responses)
// Request : req_valid/req_ready handshake with we, size (00 B, 01 H, 10 W,
//           11 reserved), unsigned flag, byte address and store data.
// Response: rsp_valid/rsp_ready handshake with extended load data and error flag.
interface dmem_if #(
    parameter int ADDR_W = 32
);
    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [1:0]        req_size;
    logic              req_unsigned;
    logic [ADDR_W-1:0] req_addr;
    logic [31:0]       req_wdata;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [31:0]       rsp_rdata;
    logic              rsp_err;

    modport master (
        output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );
endinterface

// File: rtl/dmem_ctrl.sv
// dmem_ctrl: single-port 32-bit data memory with one outstanding request,
// byte/halfword/word accesses, sign/zero extension and LATENCY wait states.
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset (memory contents are not reset)
//   bus   : dmem_if.slave request/response bus
// Parameters: DEPTH (words, power of two >= 4), ADDR_W (byte address width),
//             LATENCY (0..15 wait cycles between accept and response).
// Optional build macro DMEM_MISALIGN_TRAP_EN: misaligned halfword/word
// accesses are reported as errors instead of being forced aligned.
module dmem_ctrl #(
    parameter int DEPTH   = 256,
    parameter int ADDR_W  = 32,
    parameter int LATENCY = 1
) (
    input  logic   clk,
    input  logic   rst_n,
    dmem_if.slave  bus
);
    localparam int IDX_W = $clog2(DEPTH);
    localparam int TOP   = IDX_W + 2;   // first address bit above the word index

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t state, state_nxt;
    logic [3:0] cnt, cnt_nxt;

    logic [3:0][7:0] mem [DEPTH];

    // latched request
    logic             we_q, uns_q, err_q;
    logic [1:0]       size_q, lane_q;
    logic [IDX_W-1:0] idx_q;

    logic [31:0] rdata_q;
    logic        rerr_q;

    logic             accept, oor, mis, req_err, enter_resp, in_idle;
    logic [IDX_W-1:0] req_idx;
    logic [3:0]       be;
    logic [3:0][7:0]  wd;

    assign req_idx = bus.req_addr[TOP-1:2];
    assign accept  = bus.req_valid && bus.req_ready;

    generate
        if (ADDR_W > TOP) begin : g_oor
            assign oor = |bus.req_addr[ADDR_W-1:TOP];
        end else begin : g_no_oor
            assign oor = 1'b0;
        end
    endgenerate

`ifdef DMEM_MISALIGN_TRAP_EN
    assign mis = ((bus.req_size == 2'b01) && bus.req_addr[0]) ||
                 ((bus.req_size == 2'b10) && (bus.req_addr[1:0] != 2'b00));
`else
    // Without the trap, lane selection below simply ignores the low bits.
    assign mis = 1'b0;
`endif

    assign req_err = (bus.req_size == 2'b11) || oor || mis;

    // Store lane enables; data is replicated so each lane sees its own byte.
    always_comb begin
        be = 4'b0000;
        wd = bus.req_wdata;
        case (bus.req_size)
            2'b00: begin
                be[bus.req_addr[1:0]] = 1'b1;
                wd = {4{bus.req_wdata[7:0]}};
            end
            2'b01: begin
                be = bus.req_addr[1] ? 4'b1100 : 4'b0011;
                wd = {2{bus.req_wdata[15:0]}};
            end
            2'b10:   be = 4'b1111;
            default: be = 4'b0000;
        endcase
    end

    // Stores commit on the acceptance edge; req_ready is low in reset, so no
    // write can happen while rst_n is asserted.
    always_ff @(posedge clk) begin
        if (accept && bus.req_we && !req_err) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i]) mem[req_idx][i] <= wd[i];
            end
        end
    end

    // With LATENCY=0 RESP is entered on the accept edge itself, so the load
    // path takes fields straight from the bus while IDLE.
    logic             cur_we, cur_uns, cur_err;
    logic [1:0]       cur_size, cur_lane;
    logic [IDX_W-1:0] cur_idx;
    logic [3:0][7:0]  rword;
    logic [7:0]       lb;
    logic [15:0]      lh;
    logic [31:0]      ld;

    assign in_idle  = (state == IDLE);
    assign cur_we   = in_idle ? bus.req_we       : we_q;
    assign cur_uns  = in_idle ? bus.req_unsigned : uns_q;
    assign cur_err  = in_idle ? req_err          : err_q;
    assign cur_size = in_idle ? bus.req_size     : size_q;
    assign cur_lane = in_idle ? bus.req_addr[1:0] : lane_q;
    assign cur_idx  = in_idle ? req_idx          : idx_q;

    always_comb begin
        rword = mem[cur_idx];
        lb    = rword[cur_lane];
        lh    = cur_lane[1] ? {rword[3], rword[2]} : {rword[1], rword[0]};
        case (cur_size)
            2'b00:   ld = cur_uns ? {24'd0, lb} : {{24{lb[7]}}, lb};
            2'b01:   ld = cur_uns ? {16'd0, lh} : {{16{lh[15]}}, lh};
            2'b10:   ld = rword;
            default: ld = 32'd0;
        endcase
        if (cur_we || cur_err) ld = 32'd0;
    end

    // FSM next state
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            IDLE: if (accept) begin
                if (LATENCY == 0) begin
                    state_nxt = RESP;
                end else begin
                    state_nxt = WAIT;
                    cnt_nxt   = (LATENCY == 0) ? 4'd0 : 4'(LATENCY - 1);
                end
            end
            WAIT: begin
                if (cnt == 4'd0) state_nxt = RESP;
                else             cnt_nxt   = cnt - 4'd1;
            end
            RESP:    if (bus.rsp_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign enter_resp = (state != RESP) && (state_nxt == RESP);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            cnt     <= 4'd0;
            we_q    <= 1'b0;
            uns_q   <= 1'b0;
            err_q   <= 1'b0;
            size_q  <= 2'b00;
            lane_q  <= 2'b00;
            idx_q   <= '0;
            rdata_q <= 32'd0;
            rerr_q  <= 1'b0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            if (accept) begin
                we_q   <= bus.req_we;
                uns_q  <= bus.req_unsigned;
                err_q  <= req_err;
                size_q <= bus.req_size;
                lane_q <= bus.req_addr[1:0];
                idx_q  <= req_idx;
            end
            if (enter_resp) begin
                rdata_q <= ld;
                rerr_q  <= cur_err;
            end
        end
    end

    assign bus.req_ready = rst_n && (state == IDLE);
    assign bus.rsp_valid = (state == RESP);
    assign bus.rsp_rdata = rdata_q;
    assign bus.rsp_err   = rerr_q;
endmodule
